// File: rtl/scr_test_sequencer.sv
// scr_test_sequencer: drives the forward/negative trigger pulses and the
// pulse-forbid line of the SCR breakdown/BOD detector, samples the detector's
// result flags once per half-cycle and latches sticky faults plus an alarm
// after FAIL_LIMIT consecutive failing full cycles.
// Optional build macro: SCR_BOD_CHECK_EN -- when defined, the BOD flags are
// sampled into o_fault[3:2] and count as failures; when undefined they are
// ignored and o_fault[3:2] stays 0.
module scr_test_sequencer #(
  parameter logic [19:0] HALF_PERIOD = 20'd500000,
  parameter logic [19:0] PULSE_WIDTH = 20'd500,
  parameter logic [15:0] ARM_CYCLES  = 16'd1000,
  parameter logic [3:0]  FAIL_LIMIT  = 4'd3
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_clear,
  input  logic [15:0] i_num_cycles,
  input  logic        i_fwd_state,
  input  logic        i_neg_state,
  input  logic        i_fwd_bod,
  input  logic        i_neg_bod,
  output logic        o_trig_forward,
  output logic        o_trig_negative,
  output logic        o_forbid,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_fault,
  output logic        o_alarm,
  output logic [15:0] o_cycle_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_FWD   = 3'd2;
  localparam logic [2:0] S_NEG   = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

`ifdef SCR_BOD_CHECK_EN
  localparam logic [3:0] FAULT_MASK = 4'b1111;
`else
  localparam logic [3:0] FAULT_MASK = 4'b0011;
`endif

  localparam logic [19:0] ARM_LAST    = {4'd0, ARM_CYCLES} - 20'd1;
  localparam logic [19:0] SAMPLE_PH   = HALF_PERIOD - 20'd2;
  localparam logic [19:0] HALF_LAST   = HALF_PERIOD - 20'd1;

  // Saturating increment for the 16-bit completed-cycle counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // Saturating increment for the 4-bit consecutive-fail counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [19:0] phase_q, phase_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] num_cycles_q, num_cycles_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [3:0]  fault_q, fault_d;
  logic [3:0]  sample_q, sample_d;
  logic        alarm_q, alarm_d;
  logic        trig_fwd_q, trig_fwd_d;
  logic        trig_neg_q, trig_neg_d;
  logic        forbid_q, forbid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        run_active_s;
  logic        sample_pt_s;
  logic        half_end_s;
  logic [3:0]  fail_next_s;
  logic [15:0] cycle_next_s;
  logic [3:0]  fwd_flags_s;
  logic [3:0]  neg_flags_s;

  assign run_active_s = (state_q == S_ARM) || (state_q == S_FWD) || (state_q == S_NEG);
  assign sample_pt_s  = (phase_q == SAMPLE_PH);
  assign half_end_s   = (phase_q == HALF_LAST);
  assign fail_next_s  = (|sample_q) ? sat_inc4(fail_cnt_q) : 4'd0;
  assign cycle_next_s = sat_inc16(cycle_cnt_q);
  // Forward half checks the opposite-polarity breakdown and forward BOD.
  assign fwd_flags_s  = {1'b0, i_fwd_bod, i_neg_state, 1'b0} & FAULT_MASK;
  // Negative half checks forward breakdown and negative BOD.
  assign neg_flags_s  = {i_neg_bod, 1'b0, 1'b0, i_fwd_state} & FAULT_MASK;

  // Next-state, counters, fault accumulation and registered-output decode.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q + 20'd1;
    cycle_cnt_d  = cycle_cnt_q;
    num_cycles_d = num_cycles_q;
    fail_cnt_d   = fail_cnt_q;
    fault_d      = fault_q;
    sample_d     = sample_q;
    alarm_d      = alarm_q;
    done_d       = 1'b0;

    if (i_stop && run_active_s) begin
      // Abort wins over everything; the partial cycle is thrown away.
      state_d  = S_IDLE;
      sample_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d      = S_ARM;
            cycle_cnt_d  = 16'd0;
            fail_cnt_d   = 4'd0;
            sample_d     = 4'd0;
            num_cycles_d = i_num_cycles;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          if (phase_q == ARM_LAST) begin
            state_d = S_FWD;
          end else begin
            state_d = S_ARM;
          end
        end
        S_FWD: begin
          if (sample_pt_s) begin
            sample_d = sample_q | fwd_flags_s;
          end else begin
            sample_d = sample_q;
          end
          if (half_end_s) begin
            state_d = S_NEG;
          end else begin
            state_d = S_FWD;
          end
        end
        S_NEG: begin
          if (sample_pt_s) begin
            sample_d = sample_q | neg_flags_s;
          end else begin
            sample_d = sample_q;
          end
          if (half_end_s) begin
            cycle_cnt_d = cycle_next_s;
            fault_d     = fault_q | sample_q;
            fail_cnt_d  = fail_next_s;
            sample_d    = 4'd0;
            // A same-clock clear wipes the fail history, so it also vetoes the alarm.
            if (!i_clear && (fail_next_s >= FAIL_LIMIT)) begin
              state_d = S_ALARM;
              alarm_d = 1'b1;
            end else if ((num_cycles_q != 16'd0) && (cycle_next_s == num_cycles_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FWD;
            end
          end else begin
            state_d = S_NEG;
          end
        end
        S_ALARM: begin
          if (i_clear) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ALARM;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (i_clear) begin
      fault_d    = 4'd0;
      alarm_d    = 1'b0;
      fail_cnt_d = 4'd0;
    end else begin
      fault_d = fault_d & FAULT_MASK;
    end

    // The phase counter restarts on every state entry.
    if (state_d != state_q) begin
      phase_d = 20'd0;
    end else begin
      phase_d = phase_q + 20'd1;
    end

    trig_fwd_d = (state_d == S_FWD) && (phase_d < PULSE_WIDTH);
    trig_neg_d = (state_d == S_NEG) && (phase_d < PULSE_WIDTH);
    forbid_d   = (state_d == S_IDLE) || (state_d == S_ALARM);
    busy_d     = (state_d == S_ARM) || (state_d == S_FWD) || (state_d == S_NEG);
  end

  // State and output registers; reset forces triggers low and forbid high.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 20'd0;
      cycle_cnt_q  <= 16'd0;
      num_cycles_q <= 16'd0;
      fail_cnt_q   <= 4'd0;
      fault_q      <= 4'd0;
      sample_q     <= 4'd0;
      alarm_q      <= 1'b0;
      trig_fwd_q   <= 1'b0;
      trig_neg_q   <= 1'b0;
      forbid_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cycle_cnt_q  <= cycle_cnt_d;
      num_cycles_q <= num_cycles_d;
      fail_cnt_q   <= fail_cnt_d;
      fault_q      <= fault_d;
      sample_q     <= sample_d;
      alarm_q      <= alarm_d;
      trig_fwd_q   <= trig_fwd_d;
      trig_neg_q   <= trig_neg_d;
      forbid_q     <= forbid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_trig_forward  = trig_fwd_q;
  assign o_trig_negative = trig_neg_q;
  assign o_forbid        = forbid_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_fault         = fault_q;
  assign o_alarm         = alarm_q;
  assign o_cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_scr_test_sequencer.sv
// Scoreboard bench for scr_test_sequencer: stimulus pushes expected events
// (trigger rising edges, done pulses, alarm rising edges) with their clock
// stamps; a monitor pops and compares whenever the DUT shows one.
module tb_scr_test_sequencer;

  localparam int HP = 100;
  localparam int PW = 5;
  localparam int AC = 10;

  localparam int EV_FWD   = 1;
  localparam int EV_NEG   = 2;
  localparam int EV_DONE  = 3;
  localparam int EV_ALARM = 4;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [15:0] num = 16'd0;
  logic        fwd_state = 1'b0, neg_state = 1'b0, fwd_bod = 1'b0, neg_bod = 1'b0;
  logic        o_trig_forward, o_trig_negative, o_forbid, o_busy, o_done, o_alarm;
  logic [3:0]  o_fault;
  logic [15:0] o_cycle_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_width = 1'b1;

  scr_test_sequencer #(
    .HALF_PERIOD(20'd100), .PULSE_WIDTH(20'd5), .ARM_CYCLES(16'd10), .FAIL_LIMIT(4'd3)
  ) dut (
    .i_clk_50m(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_num_cycles(num), .i_fwd_state(fwd_state), .i_neg_state(neg_state),
    .i_fwd_bod(fwd_bod), .i_neg_bod(neg_bod),
    .o_trig_forward(o_trig_forward), .o_trig_negative(o_trig_negative),
    .o_forbid(o_forbid), .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault),
    .o_alarm(o_alarm), .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Expected trigger rising edges for n full cycles starting at clock stamp s.
  function automatic void push_cycles(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      push_ev(EV_FWD, s + AC + 2 * HP * k, 0);
      push_ev(EV_NEG, s + AC + 2 * HP * k + HP, 0);
    end
  endfunction

  task automatic got(input int kind, input int val);
    ev_t e;
    vectors = vectors + 1;
    if (exp_q.size() == 0) begin
      miscompares = miscompares + 1;
      $display("FAIL unexpected_event: got kind %0d val %0d at cyc %0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        miscompares = miscompares + 1;
        $display("FAIL event: got kind %0d cyc %0d val %0d, expected kind %0d cyc %0d val %0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  logic p_fwd = 1'b0, p_neg = 1'b0, p_alarm = 1'b0;
  int   fwd_w = 0, neg_w = 0;

  // Monitor: pops the scoreboard on each DUT event and checks pulse widths.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_fwd = 1'b0; p_neg = 1'b0; p_alarm = 1'b0; fwd_w = 0; neg_w = 0;
    end else begin
      if (o_trig_forward) fwd_w = fwd_w + 1;
      else begin
        if (p_fwd && chk_width) chk("fwd_pulse_width", fwd_w, PW);
        fwd_w = 0;
      end
      if (o_trig_negative) neg_w = neg_w + 1;
      else begin
        if (p_neg && chk_width) chk("neg_pulse_width", neg_w, PW);
        neg_w = 0;
      end
      if (o_trig_forward && !p_fwd) got(EV_FWD, 0);
      if (o_trig_negative && !p_neg) got(EV_NEG, 0);
      if (o_done) got(EV_DONE, int'(o_cycle_cnt));
      if (o_alarm && !p_alarm) got(EV_ALARM, int'(o_fault));
      p_fwd = o_trig_forward; p_neg = o_trig_negative; p_alarm = o_alarm;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start(input logic [15:0] n, output int s);
    @(negedge clk);
    num = n; start = 1'b1; s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  int s;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_forbid", o_forbid, 1);
    chk("reset_trig", {o_trig_forward, o_trig_negative, o_busy, o_done, o_alarm}, 0);
    chk("reset_fault_cnt", {o_fault, o_cycle_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two clean cycles
    do_start(16'd2, s);
    push_cycles(s, 2);
    push_ev(EV_DONE, s + AC + 4 * HP, 2);
    chk("t1_forbid_after_start", o_forbid, 0);
    chk("t1_busy_after_start", o_busy, 1);
    wait_until(s + AC + 4 * HP + 2);
    chk("t1_cycle_cnt", o_cycle_cnt, 2);
    chk("t1_fault", o_fault, 0);
    chk("t1_forbid_end", o_forbid, 1);
    chk("t1_busy_end", o_busy, 0);

    // 2: forward breakdown held, continuous -> alarm after third cycle
    fwd_state = 1'b1;
    do_start(16'd0, s);
    push_cycles(s, 3);
    push_ev(EV_ALARM, s + AC + 6 * HP, 1);
    wait_until(s + AC + 3 * HP);
    chk("t2_fault_after_c1", o_fault, 1);
    wait_until(s + AC + 9 * HP);
    chk("t2_alarm_state_forbid", o_forbid, 1);
    chk("t2_alarm_state_busy", o_busy, 0);
    chk("t2_alarm_fault", o_fault, 1);
    fwd_state = 1'b0;
    pulse_clear();
    chk("t2_alarm_cleared", o_alarm, 0);
    chk("t2_fault_cleared", o_fault, 0);
    chk("t2_idle_forbid", o_forbid, 1);

    // 3: fail, fail, clean, fail, fail -> no alarm, fault sticky
    do_start(16'd5, s);
    push_cycles(s, 5);
    push_ev(EV_DONE, s + AC + 10 * HP, 5);
    for (int k = 0; k < 5; k++) begin
      wait_until(s + AC + 20 + 2 * HP * k);
      fwd_state = (k != 2);
    end
    wait_until(s + AC + 10 * HP + 3);
    fwd_state = 1'b0;
    chk("t3_no_alarm", o_alarm, 0);
    chk("t3_fault_sticky", o_fault, 1);
    chk("t3_cycle_cnt", o_cycle_cnt, 5);
    pulse_clear();

    // 4: stop at FWD phase 50 of the second cycle
    do_start(16'd0, s);
    push_cycles(s, 1);
    push_ev(EV_FWD, s + AC + 2 * HP, 0);
    wait_until(s + AC + 2 * HP + 50);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_forbid", o_forbid, 1);
    chk("t4_busy", o_busy, 0);
    chk("t4_cycle_cnt", o_cycle_cnt, 1);
    wait_until(cyc + 3 * HP);
    chk("t4_no_done_cnt", o_cycle_cnt, 1);

    // 4b: stop during a forward pulse drops the trigger at once
    chk_width = 1'b0;
    do_start(16'd0, s);
    push_ev(EV_FWD, s + AC, 0);
    wait_until(s + AC + 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4b_trig_dropped", o_trig_forward, 0);
    chk("t4b_forbid", o_forbid, 1);
    repeat (3) @(negedge clk);
    chk_width = 1'b1;

    // 5: negative BOD only
    neg_bod = 1'b1;
`ifdef SCR_BOD_CHECK_EN
    do_start(16'd0, s);
    push_cycles(s, 3);
    push_ev(EV_ALARM, s + AC + 6 * HP, 8);
    wait_until(s + AC + 6 * HP + 3);
    chk("t5_fault_bod", o_fault, 8);
    chk("t5_alarm", o_alarm, 1);
    neg_bod = 1'b0;
    pulse_clear();
`else
    do_start(16'd3, s);
    push_cycles(s, 3);
    push_ev(EV_DONE, s + AC + 6 * HP, 3);
    wait_until(s + AC + 6 * HP + 3);
    chk("t5_fault_ignored", o_fault, 0);
    chk("t5_no_alarm", o_alarm, 0);
    neg_bod = 1'b0;
`endif

    // 6: asynchronous reset during a negative pulse
    chk_width = 1'b0;
    do_start(16'd0, s);
    push_cycles(s, 1);
    wait_until(s + AC + HP + 2);
    chk("t6_neg_high_before_rst", o_trig_negative, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_neg_low_async", o_trig_negative, 0);
    chk("t6_forbid_async", o_forbid, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_width = 1'b1;
    chk("t6_idle_busy", o_busy, 0);
    do_start(16'd1, s);
    push_cycles(s, 1);
    push_ev(EV_DONE, s + AC + 2 * HP, 1);
    wait_until(s + AC + 2 * HP + 5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scr_test_sequencer.md
# scr_test_sequencer

Sequencer for the SCR breakdown/BOD test in the light-and-electricity box. Drives the forward/negative trigger pulses and the pulse-forbid line of the breakdown detector. Samples the detector's four result flags at fixed points in each half-cycle and accumulates sticky fault flags. Latches an alarm and re-asserts forbid after a configurable run of consecutive failing cycles.

## Interface
Parameters:
- HALF_PERIOD, 20'd500000: half-cycle length in clocks (10 ms at 50 MHz); legal 16..2^20-1.
- PULSE_WIDTH, 20'd500: trigger pulse high time in clocks (10 us); must be < HALF_PERIOD-2.
- ARM_CYCLES, 16'd1000: clocks between forbid release and first forward pulse.
- FAIL_LIMIT, 4'd3: consecutive failing full cycles that raise alarm; legal 1..15.

Ports (one clock; reset is asynchronous and active-low):
- i_clk_50m  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-clock start request
- i_stop  in  1  one-clock abort request
- i_clear  in  1  one-clock clear of sticky flags and alarm
- i_num_cycles  in  16  full cycles to run; 0 = continuous
- i_fwd_state  in  1  detector forward breakdown flag, 1 = fault
- i_neg_state  in  1  detector negative breakdown flag, 1 = fault
- i_fwd_bod  in  1  detector forward BOD flag, 1 = fault
- i_neg_bod  in  1  detector negative BOD flag, 1 = fault
- o_trig_forward  out  1  forward trigger pulse to detector/driver
- o_trig_negative  out  1  negative trigger pulse
- o_forbid  out  1  pulse forbid, 1 = forbidden
- o_busy  out  1  high in ARM/FWD/NEG states
- o_done  out  1  one-clock pulse on normal completion
- o_fault  out  4  sticky {neg_bod, fwd_bod, neg_state, fwd_state}
- o_alarm  out  1  sticky alarm
- o_cycle_cnt  out  16  completed full cycles in current run

## Operation
- States: IDLE, ARM, FWD, NEG, ALARM. One 20-bit phase counter, reset to 0 on every state entry.
- IDLE: o_forbid=1. On i_start → ARM; clears o_cycle_cnt and the consecutive-fail counter. Sticky faults are not cleared.
- ARM: o_forbid=0. After ARM_CYCLES clocks → FWD.
- FWD: o_trig_forward=1 for phase 0..PULSE_WIDTH-1. At phase HALF_PERIOD-2, sample i_neg_state and i_fwd_bod into the cycle-fail vector. At phase HALF_PERIOD-1 → NEG.
- NEG: o_trig_negative=1 for phase 0..PULSE_WIDTH-1. At phase HALF_PERIOD-2, sample i_fwd_state and i_neg_bod. At phase HALF_PERIOD-1, the full cycle ends:
  - o_cycle_cnt increments, saturating at 16'hFFFF.
  - Sampled bits are OR-ed into o_fault.
  - If any bit is set, fail_cnt increments; otherwise fail_cnt clears to 0.
  - If fail_cnt reaches FAIL_LIMIT → ALARM, o_alarm=1.
  - Else if i_num_cycles≠0 and o_cycle_cnt reaches i_num_cycles → IDLE with o_done pulse.
  - Else → FWD.
- ALARM: o_forbid=1, triggers 0. Stays until i_clear → IDLE.
- i_clear: in any state, clears o_fault, o_alarm and fail_cnt. It does not change state, except that ALARM exits to IDLE.
- i_stop: in ARM/FWD/NEG → IDLE next clock, triggers drop immediately, no o_done, partial-cycle samples discarded. Ignored in IDLE/ALARM.
- Priority for same-clock events: i_stop > alarm transition > done/continue. i_start is ignored unless in IDLE.
- The first cycle's FWD-half samples are taken normally. The detector is free-running, so no masking is applied.
- i_num_cycles is sampled at i_start and held for the run.

## Timing
- Reset values: o_forbid=1, all other outputs 0, state IDLE.
- All outputs are registered. i_start at clock n gives o_forbid=0 and o_busy=1 at n+1. o_trig_forward rises at n+1+ARM_CYCLES.
- Trigger rising edges are exactly HALF_PERIOD clocks apart (forward to negative, negative to next forward).
- Sample point is one clock before the half-cycle boundary. Flags must be stable at phase HALF_PERIOD-2.
- o_done and o_alarm assert on the clock after the final NEG phase HALF_PERIOD-1.
- Reset mid-run: triggers are forced low and forbid high asynchronously.

## Configuration
- SCR_BOD_CHECK_EN defined: BOD flags are sampled, set o_fault[3:2] and count as failures.
- SCR_BOD_CHECK_EN undefined: i_fwd_bod and i_neg_bod are ignored, o_fault[3:2] is tied 0, and only breakdown state flags drive fail_cnt and alarm.

## Test plan
Bench parameters: HALF_PERIOD=100, PULSE_WIDTH=5, ARM_CYCLES=10, FAIL_LIMIT=3.
1. i_num_cycles=2, all flags 0, i_start → forward rises 11 clocks later, negative 100 clocks after, 4 pulses of 5 clocks; o_done one clock; o_cycle_cnt=2; o_fault=0; o_forbid returns 1.
2. i_fwd_state=1 held, continuous → o_fault=4'b0001; o_alarm after 3rd cycle; state ALARM with forbid=1, no further triggers; i_clear → o_alarm=0, o_fault=0, IDLE.
3. Flag failing on cycles 1 and 2, clean on 3, failing on 4 and 5 → no alarm (fail_cnt reset); o_fault stays set.
4. i_stop at FWD phase 50 → triggers stop, forbid=1 next clock, no o_done, o_cycle_cnt unchanged.
5. i_neg_bod=1 only: with SCR_BOD_CHECK_EN → o_fault=4'b1000 and alarm after 3 cycles; without it → o_fault=0 and no alarm.
6. Assert i_rst_n low during NEG pulse → o_trig_negative=0 and o_forbid=1 immediately; after release, state is IDLE.
